// File: rtl/modexp_pkg.sv
// Shared constants and state encoding for the modular-exponentiation sequencer.
package modexp_pkg;

    localparam logic [31:0] DEFAULT_P     = 32'd4294967291;
    localparam logic [32:0] DEFAULT_MU    = 33'd4294967301;
    localparam int unsigned DEFAULT_EXP_W = 32;

    function automatic int unsigned idx_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned IDX_W   = idx_width(DEFAULT_EXP_W);
    localparam int unsigned LATENCY = 4 * DEFAULT_EXP_W + 3;

    typedef enum logic [2:0] {
        StIdle,
        StLdIss,
        StLdWait,
        StSqIss,
        StSqWait,
        StMuIss,
        StMuWait,
        StDone
    } state_e;

endpackage

// File: rtl/modmul_core.sv
// Registered 32x32 product followed by combinational Barrett reduction mod P.
module modmul_core
    import modexp_pkg::*;
#(
    parameter logic [31:0] P  = DEFAULT_P,
    parameter logic [32:0] MU = DEFAULT_MU
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r
);

    logic [63:0] prod_q;
    logic [96:0] pm;
    logic [31:0] q;
    logic [63:0] qp;
    logic [64:0] rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
        end else begin
            prod_q <= {32'd0, a} * {32'd0, b};
        end
    end

    assign pm  = {33'd0, prod_q} * {64'd0, MU};
    assign q   = 32'(pm >> 64);
    assign qp  = {32'd0, q} * {32'd0, P};
    assign rem = {1'b0, prod_q} - {1'b0, qp};

    // The estimate q is at most one short of the true quotient, so one correction suffices.
    always_comb begin
        r = 32'(rem);
        if (rem[64]) begin
            r = 32'(rem + {33'd0, P});
        end else if (rem >= {33'd0, P}) begin
            r = 32'(rem - {33'd0, P});
        end
    end

endmodule

// File: rtl/modexp_ctrl.sv
// Constant-time left-to-right square-and-multiply sequencer around a shared modmul_core.
module modexp_ctrl
    import modexp_pkg::*;
#(
    parameter logic [31:0] P     = DEFAULT_P,
    parameter logic [32:0] MU    = DEFAULT_MU,
    parameter int unsigned EXP_W = DEFAULT_EXP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base,
    input  logic [EXP_W-1:0] exp,
    output logic             busy,
    output logic             done,
    output logic [31:0]      result
);

    localparam int unsigned IdxW = idx_width(EXP_W);

    state_e            state;
    logic [31:0]       acc_q;
    logic [31:0]       base_q;
    logic [EXP_W-1:0]  exp_q;
    logic [IdxW-1:0]   idx_q;
    logic [31:0]       mm_a;
    logic [31:0]       mm_b;
    logic [31:0]       mm_r;

    // Operands are only meaningful in the *_ISS states; the product is registered there.
    always_comb begin
        mm_a = acc_q;
        mm_b = base_q;
        unique case (state)
            StLdIss: begin
                mm_a = base_q;
                mm_b = 32'd1;
            end
            StSqIss: begin
                mm_a = acc_q;
                mm_b = acc_q;
            end
            default: begin
                mm_a = acc_q;
                mm_b = base_q;
            end
        endcase
    end

    modmul_core #(
        .P  (P),
        .MU (MU)
    ) u_modmul_core (
        .clk (clk),
        .rst (rst),
        .a   (mm_a),
        .b   (mm_b),
        .r   (mm_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            acc_q  <= '0;
            base_q <= '0;
            exp_q  <= '0;
            idx_q  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        base_q <= base;
                        exp_q  <= exp;
                        acc_q  <= 32'd1;
                        idx_q  <= IdxW'(EXP_W - 1);
                        busy   <= 1'b1;
                        state  <= StLdIss;
                    end
                end
                StLdIss:  state <= StLdWait;
                StLdWait: begin
                    base_q <= mm_r;
                    state  <= StSqIss;
                end
                StSqIss:  state <= StSqWait;
                StSqWait: begin
                    acc_q <= mm_r;
                    state <= StMuIss;
                end
                StMuIss:  state <= StMuWait;
                StMuWait: begin
                    // Multiply always runs; a clear exponent bit just discards it.
                    if (exp_q[idx_q]) begin
                        acc_q <= mm_r;
                    end
                    if (idx_q == '0) begin
                        result <= exp_q[idx_q] ? mm_r : acc_q;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= StDone;
                    end else begin
                        idx_q <= idx_q - IdxW'(1);
                        state <= StSqIss;
                    end
                end
                StDone:   state <= StIdle;
                default:  state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
- Sequencer that computes result = base^exp mod P using left-to-right square-and-multiply.
- Time-multiplexes a single 32-bit modular multiply/Barrett-reduce datapath (sub-module modmul_core) across all steps.
- Sits in the authentication path, feeding challenge/response arithmetic.
- Constant-time by construction: every exponent bit costs the same cycles regardless of value.

Parameters:
- P, 32'd4294967291, odd prime modulus (2^32-5).
- MU, 33'd4294967301, Barrett constant floor(2^64/P); must match P.
- EXP_W, 32, exponent width in bits (1..64).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- base  in  32  operand; any value, including >= P.
- exp  in  EXP_W  exponent.
- busy  out  1  high while a computation is in progress.
- done  out  1  one-cycle pulse when result is valid.
- result  out  32  base^exp mod P; held until the next accepted start.

Behaviour:
- Reset: when rst=1 at a clock edge, state goes to IDLE and busy=0, done=0, result=0. Applies mid-operation too: the computation is abandoned with no done pulse.
- States: IDLE, LD_ISS, LD_WAIT, SQ_ISS, SQ_WAIT, MU_ISS, MU_WAIT, DONE.
- IDLE: on start=1, latch base into base_r and exp into exp_r; set acc=1 and bit index i=EXP_W-1; go to LD_ISS. exp/base changes after this edge are ignored.
- modmul_core timing: operands presented in an *_ISS cycle are multiplied and the 64-bit product is registered at that edge. The reduced value is valid during the following *_WAIT cycle and is captured at the end of that cycle. Every multiply therefore takes 2 cycles.
- LD_ISS/LD_WAIT: compute base_r*1 mod P and write it back to base_r. This normalises base >= P. Then go to SQ_ISS.
- SQ_ISS/SQ_WAIT: acc = acc*acc mod P. Then go to MU_ISS.
- MU_ISS/MU_WAIT: t = acc*base_r mod P is always computed. If exp_r[i]=1, acc=t; otherwise t is discarded (dummy multiply for constant time).
  - If i==0, go to DONE.
  - Otherwise decrement i and go to SQ_ISS.
- DONE: assert done=1 for exactly this cycle and drive result=acc (result register updated at the edge entering DONE). Return to IDLE.
- busy: 1 in every state except IDLE and DONE.
- Latency: start in cycle 0 gives done in cycle 4*EXP_W+3, with no dependence on data. EXP_W=32 gives 131 cycles.
- start while busy or in DONE is ignored (no queuing). A start in the cycle after DONE is accepted normally.
- Arithmetic widths:
  - Product is 64 bits.
  - Barrett estimate q = (prod*MU)>>64, truncated to 32 bits.
  - r = prod - q*P is computed in 65 bits.
  - Correction: +P if r is negative; -P if r >= P.
  - Output is always < P.
- exp=0: result=1 for any base, including base=0 (0^0 defined as 1).
- base equal to a multiple of P, with exp>0: result=0.

Decomposition:
- Package modexp_pkg:
  - P, MU, EXP_W defaults.
  - State encoding (3-bit localparams / enum).
  - Derived constant IDX_W = clog2(EXP_W).
  - LATENCY = 4*EXP_W+3, for the bench.
- Sub-module modmul_core(clk, rst, a[31:0], b[31:0], r[31:0]):
  - 32x32 multiply into a registered product stage, then combinational Barrett reduction with final correction.
  - 1-cycle latency, synchronous active-high reset.
- The controller owns the FSM, the index counter, and the acc/base_r/exp_r registers.

Test Plan:
- base=3, exp=5 -> done in cycle 131, result=243, busy high in cycles 1..130.
- base=2, exp=32 -> result=5 (2^32 mod P); base=4294967290 (P-1), exp=2 -> result=1.
- base=4294967293 (P+2), exp=3 -> result=8 (normalisation path); base=P, exp=7 -> result=0.
- exp=0 with base=0 and with base=12345 -> result=1 both times, latency still 131.
- Second start pulses at cycles 10 and 60 during a run -> ignored, single done at 131; start at cycle 132 -> accepted, next done at 263.
- rst=1 at cycle 50 of a run -> next cycle busy=0, done=0, result=0, state IDLE. A fresh start then gives the correct result with full latency.
